// File: rtl/basket_text_buffer.sv
// Character-stream text buffer: NUM_LINES x CHARS_PER_LINE codes, filled line by line,
// with either stall-when-full or a one-line-per-cycle scroll, and a swept clear.
module basket_text_buffer #(
  parameter int                NUM_LINES      = 12,
  parameter int                CHARS_PER_LINE = 9,
  parameter int                CHAR_W         = 7,
  parameter logic [CHAR_W-1:0] BLANK_CODE     = 7'h20,
  parameter logic [CHAR_W-1:0] EOL_CODE       = 7'h0A,
  parameter bit                SCROLL         = 1'b0
) (
  input  logic                                        CLK,
  input  logic                                        RESET_N,
  input  logic                                        clear,
  input  logic                                        char_valid,
  input  logic [CHAR_W-1:0]                           char_data,
  output logic                                        char_ready,
  output logic [NUM_LINES*CHARS_PER_LINE*CHAR_W-1:0]  words,
  output logic [$clog2(NUM_LINES+1)-1:0]              line_count,
  output logic                                        full,
  output logic                                        busy
);
  // state      | meaning
  // ACCEPT     | taking characters at (cur_line, cur_col)
  // CLEARING   | blanking line idx per cycle, 0..NUM_LINES-1
  // SCROLLING  | copying line idx+1 into idx, last cycle blanks the bottom line
  // FULL       | bottom line committed with SCROLL=0; only clear/reset leaves

  localparam int LN_W   = $clog2(NUM_LINES);
  localparam int COL_W  = $clog2(CHARS_PER_LINE);
  localparam int LC_W   = $clog2(NUM_LINES + 1);
  localparam int LINE_W = CHARS_PER_LINE * CHAR_W;
  localparam logic [LN_W-1:0]  LAST_LINE = LN_W'(NUM_LINES - 1);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(CHARS_PER_LINE - 1);
  localparam logic [LC_W-1:0]  LC_MAX    = LC_W'(NUM_LINES);

  typedef enum logic [1:0] {ST_ACCEPT, ST_CLEARING, ST_SCROLLING, ST_FULL} state_t;

  state_t            state_q;
  logic [LN_W-1:0]   cur_line_q;
  logic [COL_W-1:0]  cur_col_q;
  logic [LC_W-1:0]   lc_q;
  logic [LN_W-1:0]   idx_q;
  logic [LN_W-1:0]   idx_nxt;
  logic [CHAR_W-1:0] mem_q [NUM_LINES][CHARS_PER_LINE];

  assign idx_nxt = idx_q + 1'b1;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_ACCEPT;
      cur_line_q <= '0;
      cur_col_q  <= '0;
      lc_q       <= '0;
      idx_q      <= '0;
      for (int l = 0; l < NUM_LINES; l++)
        for (int c = 0; c < CHARS_PER_LINE; c++)
          mem_q[l][c] <= BLANK_CODE;
    end else if (clear) begin
      // clear outranks everything, including a pending transfer and a running sweep
      state_q    <= ST_CLEARING;
      cur_line_q <= '0;
      cur_col_q  <= '0;
      lc_q       <= '0;
      idx_q      <= '0;
    end else begin
      case (state_q)
        ST_ACCEPT: begin
          if (char_valid) begin
            if (char_data != EOL_CODE)
              mem_q[cur_line_q][cur_col_q] <= char_data;
            if (char_data == EOL_CODE || cur_col_q == LAST_COL) begin
              cur_col_q <= '0;
              if (lc_q != LC_MAX)
                lc_q <= lc_q + 1'b1;
              if (cur_line_q != LAST_LINE) begin
                cur_line_q <= cur_line_q + 1'b1;
              end else if (SCROLL) begin
                state_q <= ST_SCROLLING;
                idx_q   <= '0;
              end else begin
                state_q <= ST_FULL;
              end
            end else begin
              cur_col_q <= cur_col_q + 1'b1;
            end
          end
        end
        ST_CLEARING: begin
          for (int c = 0; c < CHARS_PER_LINE; c++)
            mem_q[idx_q][c] <= BLANK_CODE;
          if (idx_q == LAST_LINE) begin
            state_q <= ST_ACCEPT;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_nxt;
          end
        end
        ST_SCROLLING: begin
          if (idx_q == LAST_LINE) begin
            for (int c = 0; c < CHARS_PER_LINE; c++)
              mem_q[LAST_LINE][c] <= BLANK_CODE;
            state_q <= ST_ACCEPT;
            idx_q   <= '0;
          end else begin
            for (int c = 0; c < CHARS_PER_LINE; c++)
              mem_q[idx_q][c] <= mem_q[idx_nxt][c];
            idx_q <= idx_nxt;
          end
        end
        ST_FULL: ;
        default: state_q <= ST_ACCEPT;
      endcase
    end
  end

  // line 0 lands in the top bits, char 0 of a line in its top CHAR_W bits
  always_comb begin
    words = '0;
    for (int l = 0; l < NUM_LINES; l++)
      for (int c = 0; c < CHARS_PER_LINE; c++)
        words[(NUM_LINES-1-l)*LINE_W + (CHARS_PER_LINE-1-c)*CHAR_W +: CHAR_W] = mem_q[l][c];
  end

  assign char_ready = (state_q == ST_ACCEPT) && !clear;
  assign line_count = lc_q;
  assign full       = (state_q == ST_FULL);
  assign busy       = (state_q == ST_CLEARING) || (state_q == ST_SCROLLING);

endmodule

// File: doc/basket_text_buffer.md
BASKET_TEXT_BUFFER -- requirements
Module: basket_text_buffer

Interface
REQ-001 Parameter NUM_LINES, default 12, number of text lines held.
REQ-002 Parameter CHARS_PER_LINE, default 9, characters per line.
REQ-003 Parameter CHAR_W, default 7, bits per character code.
REQ-004 Parameter BLANK_CODE, default 7'h20, code stored in every unwritten position.
REQ-005 Parameter EOL_CODE, default 7'h0A, end-of-line marker code; never stored.
REQ-006 Parameter SCROLL, default 0; 1 = scroll when full, 0 = stall when full.
REQ-007 CLK  input  1  single clock; all state changes on rising edge.
REQ-008 RESET_N  input  1  reset, asynchronous, active-low.
REQ-009 clear  input  1  single-cycle request to blank the whole buffer.
REQ-010 char_valid  input  1  char_data holds a character to append.
REQ-011 char_data  input  7  character code or EOL_CODE.
REQ-012 char_ready  output  1  block accepts char_data this cycle.
REQ-013 words  output  756  flattened buffer, line 0 at [755:693], line 11 at [62:0]; char 0 of a line is its most-significant 7 bits.
REQ-014 line_count  output  4  committed lines, 0..12.
REQ-015 full  output  1  high while in FULL state.
REQ-016 busy  output  1  high while in CLEARING or SCROLLING.

Function
REQ-017 States: ACCEPT, CLEARING, SCROLLING, FULL.
REQ-018 Transfer occurs on an edge where char_valid & char_ready are both high; char_ready = (state==ACCEPT) & !clear, with no dependence on char_valid.
REQ-019 Non-EOL transfer writes char_data at (cur_line, cur_col); words reflects it one cycle after the transfer edge; cur_col increments.
REQ-020 Line commit occurs on a write at cur_col==8 or on any EOL transfer; commit sets cur_col=0 and increments line_count (saturating at 12).
REQ-021 EOL at cur_col==0 commits an all-blank line; EOL mid-line leaves remaining positions blank.
REQ-022 Commit with cur_line<11 increments cur_line; state stays ACCEPT.
REQ-023 Commit with cur_line==11 and SCROLL=0 enters FULL; char_ready stays low until clear or reset.
REQ-024 Commit with cur_line==11 and SCROLL=1 enters SCROLLING; cur_line stays 11.
REQ-025 SCROLLING lasts exactly 12 cycles: cycles 1-11 copy line i+1 into line i, for i=0..10, one line per cycle; cycle 12 writes BLANK_CODE to all of line 11; then the block returns to ACCEPT.
REQ-026 clear, when sampled high in any state, enters CLEARING and sets cur_line=0, cur_col=0, line_count=0.
REQ-027 CLEARING lasts exactly 12 cycles, blanking line 0..11 in order (one line per cycle), then returns to ACCEPT.
REQ-028 clear during CLEARING restarts the sweep at line 0; clear during SCROLLING aborts the scroll.
REQ-029 clear and char_valid high on the same edge: no transfer (char_ready low); clear wins.
REQ-030 busy = (state==CLEARING | state==SCROLLING); full = (state==FULL).
REQ-031 Positions never written by a transfer SHALL always read BLANK_CODE.

Reset
REQ-032 RESET_N low immediately forces all 108 words positions to BLANK_CODE, state=ACCEPT, cur_line=0, cur_col=0, line_count=0, full=0, busy=0, char_ready=1 (if clear=0).
REQ-033 Reset asserted mid-CLEARING or mid-SCROLLING abandons the operation with no partial state retained.
REQ-034 Reset release is applied to all flops together on the same clock edge.

Verification
REQ-035 Reset, then stream "ABCDEFGHI" -> words[755:693]=codes A..I, line_count=1, cur_line=1, remaining lines all 7'h20.
REQ-036 Send 'X', EOL, EOL -> line 0 = X followed by 8 blanks, line 1 all blank, line_count=2.
REQ-037 SCROLL=0: commit 12 lines -> full=1, char_ready=0; held char_valid not accepted; clear -> busy for 12 cycles, then char_ready=1 and words all blank.
REQ-038 SCROLL=1: commit 13 lines L0..L12 -> busy for 12 cycles after the 12th commit; afterwards line 0=L1, line 11 blank until L12 is written; line_count=12.
REQ-039 clear asserted with char_valid on the same edge, and again 5 cycles into CLEARING -> character dropped, sweep restarts, busy high for 12 cycles after the second clear.
REQ-040 RESET_N pulsed low during SCROLLING cycle 6 -> all outputs at reset values asynchronously, with no clock edge needed.
